// File: rtl/para_streamer_layer7_pkg.sv
// Shared types for the layer-7 parameter streamer: mode/valid encodings,
// segment and FSM enums, and the buffered word record (data + segment tag).
package para_streamer_layer7_pkg;

  localparam int PARA_WIDTH = 16;

  localparam logic LOAD_PARA = 1'b1;
  localparam logic CALC      = 1'b0;
  localparam logic DATAVALID = 1'b1;
  localparam logic RSTVALID  = 1'b0;

  typedef enum logic [2:0] {
    SEG_RSIGN = 3'd0,
    SEG_BN_A  = 3'd1,
    SEG_BN_B  = 3'd2,
    SEG_BETA  = 3'd3,
    SEG_GAMMA = 3'd4,
    SEG_ZETA  = 3'd5
  } seg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    seg_e                          seg;
    logic signed [PARA_WIDTH-1:0]  data;
  } para_word_t;

  // Saturates at the last segment so a stray extra step can never wrap to rsign.
  function automatic seg_e seg_next(input seg_e s);
    return (s == SEG_ZETA) ? SEG_ZETA : seg_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/para_skid_buf.sv
// Two-entry word buffer (head + skid) holding returned reads not yet emitted,
// plus the read-issue credit derived from occupancy and in-flight reads.
module para_skid_buf
  import para_streamer_layer7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  para_word_t push_word,
  input  logic       pop,
  input  logic       in_flight,
  input  logic       emit,
  output para_word_t head_word,
  output logic       empty,
  output logic       credit
);

  logic [1:0] cnt_q, cnt_d;
  para_word_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic       full;
  logic [2:0] load;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign head_word = ent0_q;

  // Words that will still be owed a slot after this cycle's emit.
  assign load   = {1'b0, cnt_q} + {2'b0, in_flight} - {2'b0, emit};
  assign credit = (load < 3'd2);

  always_comb begin
    cnt_d  = cnt_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push && !(full && !pop)) begin
      if (cnt_d == 2'd0) ent0_d = push_word;
      else               ent1_d = push_word;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

endmodule

// File: rtl/para_streamer_layer7.sv
// Streams the packed layer-7 parameter image from a synchronous memory as a
// serial word stream (rsign, bn_a, bn_b, beta, gamma, zeta) with stall support.
module para_streamer_layer7
  import para_streamer_layer7_pkg::*;
#(
  parameter int FM_DEPTH    = 256,
  parameter int CHANNEL_NUM = 512,
  parameter int ADDR_WIDTH  = 12,
  parameter int BASE_ADDR   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stall,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [PARA_WIDTH-1:0]        mem_rd_data,
  output logic                         mode,
  output logic                         data_e_para,
  output logic signed [PARA_WIDTH-1:0] para_out,
  output logic [2:0]                   seg_o,
  output logic                         busy,
  output logic                         done
);

  localparam int TOTAL = FM_DEPTH + 5 * CHANNEL_NUM;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SEG_MAX = (FM_DEPTH > CHANNEL_NUM) ? FM_DEPTH : CHANNEL_NUM;
  localparam int SEG_W = $clog2(SEG_MAX + 1);

  localparam logic [CNT_W-1:0]      TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]      LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [SEG_W-1:0]      FM_C    = SEG_W'(FM_DEPTH);
  localparam logic [SEG_W-1:0]      CH_C    = SEG_W'(CHANNEL_NUM);
  localparam logic [SEG_W-1:0]      ONE_C   = SEG_W'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  state_e           state_q;
  logic             busy_q, done_q, mode_q;
  logic [CNT_W-1:0] rd_idx_q;
  seg_e             rd_seg_q;
  logic [SEG_W-1:0] seg_left_q;

  logic                         rd_vld_q, rd_vld_d;
  seg_e                         ret_seg_q, ret_seg_d;
  logic                         data_e_q, data_e_d;
  logic signed [PARA_WIDTH-1:0] para_q, para_d;
  seg_e                         seg_q, seg_d;

  logic       issue, emit, buf_push, buf_pop, buf_empty, credit;
  para_word_t buf_head, ret_word, head;

  assign issue     = (state_q == ST_STREAM) & ~stall & (rd_idx_q < TOTAL_C) & credit;
  assign mem_rd_en = issue;
  assign mem_addr  = BASE_C + ADDR_WIDTH'(rd_idx_q);

  // Returning data bypasses the buffer when it is empty, giving 1 word/cycle.
  always_comb begin
    ret_word.seg  = ret_seg_q;
    ret_word.data = mem_rd_data;
    head      = buf_empty ? ret_word : buf_head;
    emit      = ~stall & (~buf_empty | rd_vld_q);
    buf_pop   = emit & ~buf_empty;
    buf_push  = rd_vld_q & ~(emit & buf_empty);
    rd_vld_d  = issue;
    ret_seg_d = issue ? rd_seg_q : ret_seg_q;
    data_e_d  = emit ? DATAVALID : RSTVALID;
    para_d    = emit ? head.data : para_q;
    seg_d     = emit ? head.seg : seg_q;
  end

  para_skid_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_word (ret_word),
    .pop       (buf_pop),
    .in_flight (rd_vld_q),
    .emit      (emit),
    .head_word (buf_head),
    .empty     (buf_empty),
    .credit    (credit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      ret_seg_q <= SEG_RSIGN;
      data_e_q  <= RSTVALID;
      para_q    <= '0;
      seg_q     <= SEG_RSIGN;
    end else begin
      rd_vld_q  <= rd_vld_d;
      ret_seg_q <= ret_seg_d;
      data_e_q  <= data_e_d;
      para_q    <= para_d;
      seg_q     <= seg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= CALC;
      rd_idx_q   <= '0;
      rd_seg_q   <= SEG_RSIGN;
      seg_left_q <= FM_C;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= ST_STREAM;
            busy_q     <= 1'b1;
            mode_q     <= LOAD_PARA;
            rd_idx_q   <= '0;
            rd_seg_q   <= SEG_RSIGN;
            seg_left_q <= FM_C;
          end
        end
        ST_STREAM: begin
          if (issue) begin
            rd_idx_q <= rd_idx_q + 1'b1;
            // Per-segment down-counter replaces a k/CHANNEL_NUM divide.
            if (seg_left_q == ONE_C) begin
              rd_seg_q   <= seg_next(rd_seg_q);
              seg_left_q <= CH_C;
            end else begin
              seg_left_q <= seg_left_q - ONE_C;
            end
            if (rd_idx_q == LAST_C) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (buf_empty && !rd_vld_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          mode_q  <= CALC;
        end
      endcase
    end
  end

  assign mode        = mode_q;
  assign data_e_para = data_e_q;
  assign para_out    = para_q;
  assign seg_o       = seg_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_para_streamer_layer7.sv
// Bench for para_streamer_layer7: table of timing scenarios on a small image,
// a mid-stream reset, and a randomly stalled full-size run against a model.
module tb_para_streamer_layer7;

  localparam int S_FM = 4, S_CH = 8, S_AW = 6, S_BASE = 8;
  localparam int S_TOTAL = S_FM + 5 * S_CH;
  localparam int B_FM = 256, B_CH = 512, B_AW = 12, B_BASE = 16;
  localparam int B_TOTAL = B_FM + 5 * B_CH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic s_start = 1'b0, s_stall = 1'b0, s_rd_en, s_mode, s_dv, s_busy, s_done;
  logic [S_AW-1:0] s_addr;
  logic [15:0] s_rd_data = 16'd0;
  logic signed [15:0] s_para;
  logic [2:0] s_seg;

  logic b_start = 1'b0, b_stall = 1'b0, b_rd_en, b_mode, b_dv, b_busy, b_done;
  logic [B_AW-1:0] b_addr;
  logic [15:0] b_rd_data = 16'd0;
  logic signed [15:0] b_para;
  logic [2:0] b_seg;

  para_streamer_layer7 #(.FM_DEPTH(S_FM), .CHANNEL_NUM(S_CH), .ADDR_WIDTH(S_AW), .BASE_ADDR(S_BASE)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_stall),
    .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rd_data(s_rd_data),
    .mode(s_mode), .data_e_para(s_dv), .para_out(s_para), .seg_o(s_seg),
    .busy(s_busy), .done(s_done));

  para_streamer_layer7 #(.FM_DEPTH(B_FM), .CHANNEL_NUM(B_CH), .ADDR_WIDTH(B_AW), .BASE_ADDR(B_BASE)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stall(b_stall),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
    .mode(b_mode), .data_e_para(b_dv), .para_out(b_para), .seg_o(b_seg),
    .busy(b_busy), .done(b_done));

  // Image contents: small image word k = k+100, big image a scrambled pattern.
  function automatic logic [15:0] big_word(input int a);
    return 16'((a * 40503 + 12345) ^ (a << 7));
  endfunction

  function automatic int exp_seg(input int k, input int fm, input int ch);
    return (k < fm) ? 0 : 1 + (k - fm) / ch;
  endfunction

  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= 16'(int'(s_addr) - S_BASE + 100);
    if (b_rd_en) b_rd_data <= big_word(int'(b_addr));
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int stall_lo;
    int stall_hi;
    int restart;
    int first;
    int gap_lo;
    int gap_hi;
    int done_at;
  } row_t;

  row_t rows[8];

  task automatic run_row(input row_t r, input int id);
    int k = 0;
    int ndone = 0;
    bit exp_dv;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      s_start = (c == 0) || (c == r.restart);
      s_stall = (c >= r.stall_lo) && (c <= r.stall_hi);
      @(negedge clk);
      exp_dv = (c >= r.first) && (c < r.done_at) && !((c >= r.gap_lo) && (c <= r.gap_hi));
      check($sformatf("row%0d dv c%0d", id, c), 64'(s_dv), 64'(exp_dv));
      check($sformatf("row%0d busy c%0d", id, c), 64'(s_busy), 64'((c >= 1) && (c < r.done_at)));
      if (c >= 1 && c < r.done_at) check($sformatf("row%0d mode c%0d", id, c), 64'(s_mode), 64'(1));
      if (c > r.done_at) check($sformatf("row%0d mode c%0d", id, c), 64'(s_mode), 64'(0));
      if (c == 1 && r.first == 3) begin
        check($sformatf("row%0d rd_en c1", id), 64'(s_rd_en), 64'(1));
        check($sformatf("row%0d addr c1", id), 64'(s_addr), 64'(S_BASE));
      end
      if (s_dv) begin
        check($sformatf("row%0d word%0d", id, k), 64'($unsigned(s_para)), 64'(k + 100));
        check($sformatf("row%0d seg%0d", id, k), 64'(s_seg), 64'(exp_seg(k, S_FM, S_CH)));
        k++;
      end
      if (s_done) begin
        ndone++;
        check($sformatf("row%0d done cycle", id), 64'(c), 64'(r.done_at));
      end
    end
    s_start = 1'b0;
    s_stall = 1'b0;
    check($sformatf("row%0d pulses", id), 64'(k), 64'(S_TOTAL));
    check($sformatf("row%0d done count", id), 64'(ndone), 64'(1));
  endtask

  initial begin
    rows[0] = '{-1, -1, -1, 3, -1, -1, 47};
    rows[1] = '{10, 14, -1, 3, 11, 15, 52};
    rows[2] = '{ 7,  7, -1, 3,  8,  8, 48};
    rows[3] = '{ 7,  8, -1, 3,  8,  9, 49};
    rows[4] = '{ 1,  1, -1, 4, -1, -1, 48};
    rows[5] = '{45, 45, -1, 3, 46, 46, 48};
    rows[6] = '{46, 46, -1, 3, -1, -1, 47};
    rows[7] = '{-1, -1, 20, 3, -1, -1, 47};

    #1;
    check("rst mode", 64'(s_mode), 64'(0));
    check("rst dv", 64'(s_dv), 64'(0));
    check("rst para", 64'($unsigned(s_para)), 64'(0));
    check("rst seg", 64'(s_seg), 64'(0));
    check("rst busy", 64'(s_busy), 64'(0));
    check("rst done", 64'(s_done), 64'(0));
    check("rst rd_en", 64'(s_rd_en), 64'(0));
    check("rst addr", 64'(s_addr), 64'(S_BASE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_row(rows[i], i);

    // Reset asserted mid-stream, then a fresh start must begin again at word 0.
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      s_start = (c == 0);
      @(negedge clk);
    end
    check("midstream dv", 64'(s_dv), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst dv", 64'(s_dv), 64'(0));
    check("async rst para", 64'($unsigned(s_para)), 64'(0));
    check("async rst seg", 64'(s_seg), 64'(0));
    check("async rst busy", 64'(s_busy), 64'(0));
    check("async rst mode", 64'(s_mode), 64'(0));
    check("async rst rd_en", 64'(s_rd_en), 64'(0));
    check("async rst addr", 64'(s_addr), 64'(S_BASE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_row(rows[0], 8);

    // Full-size image under random 30% stall against the memory-order model.
    begin
      int k = 0;
      int ndone = 0;
      bit stall_prev = 1'b0;
      @(posedge clk);
      #1;
      b_start = 1'b1;
      @(posedge clk);
      #1;
      b_start = 1'b0;
      for (int c = 0; c < 20000 && ndone == 0; c++) begin
        b_stall = ($urandom_range(0, 99) < 30);
        @(negedge clk);
        if (b_dv) begin
          if (stall_prev) check("emit after stall", 64'(1), 64'(0));
          if (k < B_TOTAL) begin
            check($sformatf("big word%0d", k), 64'($unsigned(b_para)), 64'(big_word(B_BASE + k)));
            check($sformatf("big seg%0d", k), 64'(b_seg), 64'(exp_seg(k, B_FM, B_CH)));
          end
          check($sformatf("big mode%0d", k), 64'(b_mode), 64'(1));
          k++;
        end
        if (b_done) ndone++;
        stall_prev = b_stall;
        @(posedge clk);
        #1;
      end
      b_stall = 1'b0;
      check("big pulses", 64'(k), 64'(B_TOTAL));
      check("big done seen", 64'(ndone), 64'(1));
      repeat (2) @(negedge clk);
      check("big busy after", 64'(b_busy), 64'(0));
      check("big mode after", 64'(b_mode), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/para_streamer_layer7.md
Name: para_streamer_layer7

Overview:
Transmit-side counterpart of the layer-7 parameter loader. On a start pulse, it reads the packed layer-7 parameter image from a synchronous parameter memory. It then emits the image as a serial word stream on mode/data_e_para/para_out, in the exact order the loader consumes:
- rsign (FM_DEPTH words)
- bn_a, bn_b, rprelu_beta, rprelu_gamma, rprelu_zeta (CHANNEL_NUM words each)

It sits between the off-chip/param SRAM controller and the layer-7 loader. It supports downstream stall.

Parameters:
FM_DEPTH, 256, number of rsign words (segment 0)
CHANNEL_NUM, 512, words per segment 1..5
ADDR_WIDTH, 12, parameter memory address width; must satisfy 2^ADDR_WIDTH >= BASE_ADDR + TOTAL
BASE_ADDR, 0, memory address of word 0 of the image
(derived) TOTAL = FM_DEPTH + 5*CHANNEL_NUM (2816 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle request to stream the whole image
stall  in  1  downstream hold; no word is emitted in a cycle with stall=1
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  PARA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
mode  out  1  LOAD_PARA while busy, else CALC
data_e_para  out  1  word valid (DATAVALID level), registered
para_out  out  PARA_WIDTH signed  parameter word, valid when data_e_para=1
seg_o  out  3  segment index (0..5) of the word on para_out
busy  out  1  high from the cycle after accepted start until the done pulse
done  out  1  one-cycle pulse after the last word is emitted

Behaviour:
- Reset values: mode=CALC, data_e_para=0, para_out=0, seg_o=0, busy=0, done=0, mem_rd_en=0, mem_addr=BASE_ADDR. All counters and the buffer are cleared.
- FSM states:
  - IDLE: start=1 -> STREAM. Index counters are cleared and busy=1 from the next cycle.
  - STREAM: issues reads. Once all TOTAL reads are issued -> DRAIN.
  - DRAIN: waits until the buffer is empty and no read is in flight -> DONE.
  - DONE: done=1 and busy=0 for one cycle, mode returns to CALC -> IDLE.
- start is ignored whenever the FSM is not in IDLE.
- Read issue:
  - mem_rd_en = (state==STREAM) & ~stall & (rd_idx<TOTAL) & credit.
  - mem_addr = BASE_ADDR + rd_idx; rd_idx increments on each issue.
- Buffer is 2 entries: an output register plus a skid register.
  - credit is true when (occupied entries + reads in flight − emit this cycle) < 2.
  - This keeps 1 word/cycle throughput when stall=0.
  - No returning read data is ever dropped, including when stall rises in the cycle the data returns.
- Emit:
  - On a cycle with buffer non-empty & stall=0, the head word is registered to para_out and data_e_para=1 in the next cycle.
  - Otherwise data_e_para=0 and para_out holds its value.
- Word order is strictly linear k=0..TOTAL-1; there is no reordering and no duplication.
- seg_o for an emitted word k:
  - 0 when k<FM_DEPTH
  - otherwise 1+(k−FM_DEPTH)/CHANNEL_NUM
  - Maintained with a down-counter per segment; no divider.
- Latency with stall=0:
  - start high in cycle 0 -> mem_rd_en first high in cycle 1 -> data_e_para first high in cycle 3.
  - Then TOTAL consecutive data_e_para cycles (cycles 3..TOTAL+2).
  - done in cycle TOTAL+3.
- mode=LOAD_PARA spans every data_e_para=1 cycle; it rises at least 1 cycle before the first word and falls the cycle after done.
- Exactly TOTAL data_e_para pulses are produced per start, independent of the stall pattern.
- Reset mid-stream returns all state to reset values immediately. Any in-flight read data is discarded. The next start restarts from k=0.
- stall held high indefinitely: the FSM stays in STREAM/DRAIN with busy=1; there is no timeout.

Decomposition:
- Shared package/defines: PARA_WIDTH, LOAD_PARA/CALC mode encodings, DATAVALID, RSTVALID, segment enum (SEG_RSIGN, SEG_BN_A, SEG_BN_B, SEG_BETA, SEG_GAMMA, SEG_ZETA), FSM state enum.
- One natural sub-module: para_skid_buf, a 2-entry PARA_WIDTH+3-bit (data+seg) buffer with push/pop/full/empty and credit output.

Test Plan:
- Small params FM_DEPTH=4, CHANNEL_NUM=8, memory holds word k=k+100, no stall, start at cycle 0:
  - data_e_para is high cycles 3..46 with para_out=100..143.
  - seg_o changes at k=4,12,20,28,36.
  - done is high at cycle 47.
- Same setup with stall high cycles 10..14:
  - No data_e_para during cycles 11..15.
  - Sequence stays gap-free in value (no loss or duplication), 44 pulses total.
  - done is delayed by exactly 5 cycles.
- stall raised exactly in the cycle a read returns, with the output register occupied:
  - The skid holds the word; the next emitted values are consecutive after stall drops.
- start pulsed again in cycle 20 while busy:
  - Ignored; still exactly 44 words and one done pulse.
- rst_n asserted at cycle 25 mid-stream:
  - All outputs take reset values asynchronously.
  - A new start emits from para_out=100 again.
- Default params, random stall at 30% duty:
  - Exactly 2816 pulses; a scoreboard against memory order passes.
  - A connected para_loader_layer7 ends with all arrays equal to the image.
